// File: rtl/alu_sequencer_pkg.sv
// Purpose: shared opcodes, FSM encoding and opcode helpers for the ALU sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package alu_ctrl_pkg;

   localparam logic [4:0] OP_NOP  = 5'b00000;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHRA = 5'b01000;
   localparam logic [4:0] OP_SHL  = 5'b01001;
   localparam logic [4:0] OP_ROR  = 5'b01010;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic is_muldiv(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

   function automatic logic is_legal(input logic [4:0] op);
      logic ok;
      ok = 1'b0;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
         OP_ROR, OP_ROL, OP_MUL, OP_DIV, OP_NEG, OP_NOT: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Purpose: bundles the request, ALU-facing and result signals of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; requests are only taken while the sequencer reports not busy.
// Ports: master = control unit / ALU side (drives request and alu_c),
//        slave  = sequencer (drives ALU operands, status and results).
interface alu_sequencer_if;
   logic        start;
   logic [4:0]  op_code;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic [63:0] alu_c;
   logic [31:0] alu_y;
   logic [31:0] alu_b;
   logic [4:0]  alu_op;
   logic        busy;
   logic        done;
   logic [31:0] result_hi;
   logic [31:0] result_lo;
   logic        hi_we;
   logic        lo_we;
   logic        illegal;

   modport master (
      output start, op_code, operand_a, operand_b, alu_c,
      input  alu_y, alu_b, alu_op, busy, done, result_hi, result_lo,
             hi_we, lo_we, illegal
   );

   modport slave (
      input  start, op_code, operand_a, operand_b, alu_c,
      output alu_y, alu_b, alu_op, busy, done, result_hi, result_lo,
             hi_we, lo_we, illegal
   );
endinterface

// File: rtl/alu_sequencer_exec_counter.sv
// Purpose: 4-bit loadable down-counter timing the EXEC phase; last flags count==1.
// Latency: load/decrement take effect on the next rising edge.
// Backpressure: none; decrement saturates at zero.
// Ports: clock, clear (sync active-high), load + load_val, dec, last.
module exec_counter (
   input  logic       clock,
   input  logic       clear,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic       last
);

   logic [3:0] count_q;

   always_ff @(posedge clock) begin
      if (clear) begin
         count_q <= 4'd0;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec && (count_q != 4'd0)) begin
         count_q <= count_q - 4'd1;
      end
   end

   assign last = (count_q == 4'd1);

endmodule

// File: rtl/alu_sequencer.sv
// Purpose: sequences one ALU operation per request and captures {hi,lo} into result registers.
// Latency: done 1 cycle after accept for simple/illegal ops, MULDIV_CYCLES cycles for mul/div.
// Backpressure: start is ignored (not queued) while busy.
// Ports: clock, clear (sync active-high), bus (alu_sequencer_if.slave).
module alu_sequencer
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned MULDIV_CYCLES = 4
) (
   input logic            clock,
   input logic            clear,
   alu_sequencer_if.slave bus
);

   localparam logic [3:0] MULDIV_LOAD = 4'(MULDIV_CYCLES);

   state_t      state_q, state_d;
   logic        accept, capture, cnt_last;
   logic        req_legal;
   logic [3:0]  load_val;
   logic [31:0] alu_y_q, alu_b_q, result_hi_q, result_lo_q;
   logic [4:0]  alu_op_q;
   logic        illegal_q, hi_flag_q, lo_flag_q;

   assign req_legal = is_legal(bus.op_code);
   // Illegal requests also pass through a one-count EXEC so their done pulse
   // lands on the same edge as a simple op.
   assign load_val  = (req_legal && is_muldiv(bus.op_code)) ? MULDIV_LOAD : 4'd1;

   exec_counter u_exec_counter (
      .clock    (clock),
      .clear    (clear),
      .load     (accept),
      .load_val (load_val),
      .dec      (state_q == EXEC),
      .last     (cnt_last)
   );

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               accept  = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (cnt_last) begin
               capture = 1'b1;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         alu_y_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= OP_NOP;
         result_hi_q <= '0;
         result_lo_q <= '0;
         illegal_q   <= 1'b0;
         hi_flag_q   <= 1'b0;
         lo_flag_q   <= 1'b0;
      end else begin
         if (accept) begin
            illegal_q <= !req_legal;
            hi_flag_q <= 1'b0;
            lo_flag_q <= 1'b0;
            if (req_legal) begin
               alu_y_q  <= bus.operand_a;
               alu_b_q  <= bus.operand_b;
               alu_op_q <= bus.op_code;
            end else begin
               result_hi_q <= '0;
               result_lo_q <= '0;
            end
         end else if (state_q == DONE) begin
            // Park the ALU on NOP so it produces zero while idle.
            alu_y_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= OP_NOP;
         end

         if (capture && !illegal_q) begin
            result_hi_q <= bus.alu_c[63:32];
            result_lo_q <= bus.alu_c[31:0];
            lo_flag_q   <= 1'b1;
            hi_flag_q   <= is_muldiv(alu_op_q);
         end
      end
   end

   assign bus.alu_y     = alu_y_q;
   assign bus.alu_b     = alu_b_q;
   assign bus.alu_op    = alu_op_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = (state_q == DONE);
   assign bus.result_hi = result_hi_q;
   assign bus.result_lo = result_lo_q;
   // Flags are only meaningful alongside done, so gate them with it.
   assign bus.hi_we     = bus.done && hi_flag_q;
   assign bus.lo_we     = bus.done && lo_flag_q;
   assign bus.illegal   = bus.done && illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Purpose: self-checking bench for alu_sequencer; the bench also plays the ALU.
// Latency: checks done timing for simple, mul/div and illegal requests.
// Backpressure: checks that start while busy is dropped.
module tb_alu_sequencer;

   localparam int MC = 4;
   localparam logic [4:0] LEGAL [13] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110,
                                         5'b00111, 5'b01000, 5'b01001, 5'b01010,
                                         5'b01011, 5'b01111, 5'b10000, 5'b10001,
                                         5'b10010};

   logic clock = 1'b0;
   logic clear;
   int   total_cnt = 0;
   int   pass_cnt  = 0;

   alu_sequencer_if bus ();

   alu_sequencer #(.MULDIV_CYCLES(MC)) dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Behavioural ALU: {hi, lo}; div gives remainder in hi, quotient in lo.
   function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      logic [63:0] r;
      logic [63:0] t;
      int          s;
      r = 64'd0;
      s = int'(b[4:0]);
      case (op)
         5'b00011: r = {32'd0, a + b};
         5'b00100: r = {32'd0, a - b};
         5'b00101: r = {32'd0, a & b};
         5'b00110: r = {32'd0, a | b};
         5'b00111: r = {32'd0, a >> s};
         5'b01000: r = {32'd0, 32'($signed(a) >>> s)};
         5'b01001: r = {32'd0, a << s};
         5'b01010: begin t = {a, a} >> s; r = {32'd0, t[31:0]}; end
         5'b01011: begin t = {a, a} << s; r = {32'd0, t[63:32]}; end
         5'b01111: r = {32'd0, a} * {32'd0, b};
         5'b10000: r = (b == 32'd0) ? 64'd0 : {a % b, a / b};
         5'b10001: r = {32'd0, 32'd0 - b};
         5'b10010: r = {32'd0, ~b};
         default:  r = 64'd0;
      endcase
      return r;
   endfunction

   function automatic logic legal_ref(input logic [4:0] op);
      foreach (LEGAL[i]) if (LEGAL[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   assign bus.alu_c = alu_fn(bus.alu_op, bus.alu_y, bus.alu_b);

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " busy"}, 64'(bus.busy), 64'd0);
      check({tag, " done"}, 64'(bus.done), 64'd0);
      check({tag, " we/illegal"}, 64'({bus.hi_we, bus.lo_we, bus.illegal}), 64'd0);
      check({tag, " alu_op"}, 64'(bus.alu_op), 64'd0);
      check({tag, " alu_y/alu_b"}, {bus.alu_y, bus.alu_b}, 64'd0);
      check({tag, " result"}, {bus.result_hi, bus.result_lo}, 64'd0);
   endtask

   // Counts done pulses over n cycles; called at a negedge, returns at a negedge.
   task automatic count_done(input int n, output int pulses);
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         @(negedge clock);
         if (bus.done) pulses++;
      end
   endtask

   // Issues one request from IDLE (called at a negedge). If inject > 0, a
   // competing add request is raised during that EXEC sample.
   task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int inject);
      logic [63:0] exp_c;
      logic        legal, md, stable;
      int          exp_lat, lat;
      legal   = legal_ref(op);
      md      = (op == 5'b01111) || (op == 5'b10000);
      exp_c   = legal ? alu_fn(op, a, b) : 64'd0;
      exp_lat = (legal && md) ? MC : 1;

      bus.start     = 1'b1;
      bus.op_code   = op;
      bus.operand_a = a;
      bus.operand_b = b;
      @(posedge clock);
      @(negedge clock);
      bus.start     = 1'b0;
      bus.op_code   = 5'($urandom);
      bus.operand_a = $urandom;
      bus.operand_b = $urandom;

      lat    = 0;
      stable = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         if (!bus.busy || bus.done ||
             bus.alu_op !== (legal ? op : 5'd0) ||
             bus.alu_y  !== (legal ? a : 32'd0) ||
             bus.alu_b  !== (legal ? b : 32'd0)) stable = 1'b0;
         if (i == inject) begin
            bus.start     = 1'b1;
            bus.op_code   = 5'b00011;
            bus.operand_a = 32'h0000_1234;
            bus.operand_b = 32'h0000_4321;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clock);
         @(negedge clock);
         if (bus.done) begin
            lat = i;
            break;
         end
      end
      bus.start = 1'b0;

      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " operands held in EXEC"}, 64'(stable), 64'd1);
      check({tag, " result"}, {bus.result_hi, bus.result_lo}, exp_c);
      check({tag, " hi_we/lo_we/illegal"}, 64'({bus.hi_we, bus.lo_we, bus.illegal}),
            64'({legal && md, legal, !legal}));
      check({tag, " busy in DONE"}, 64'(bus.busy), 64'd1);

      @(posedge clock);
      @(negedge clock);
      check({tag, " idle after done"}, 64'({bus.busy, bus.done, bus.hi_we, bus.lo_we}), 64'd0);
      check({tag, " alu parked"}, {27'd0, bus.alu_op, bus.alu_y}, 64'd0);
      check({tag, " result held"}, {bus.result_hi, bus.result_lo}, exp_c);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          pulses;
      logic [4:0]  op;
      logic [31:0] a, b;
      int          r;

      clear         = 1'b1;
      bus.start     = 1'b0;
      bus.op_code   = 5'd0;
      bus.operand_a = 32'd0;
      bus.operand_b = 32'd0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      clear = 1'b0;
      check_all_zero("reset");

      run_op("add 5+7", 5'b00011, 32'd5, 32'd7, 0);
      run_op("mul 2^16*2^16", 5'b01111, 32'h0001_0000, 32'h0001_0000, 0);
      run_op("div 17/5", 5'b10000, 32'd17, 32'd5, 0);
      run_op("illegal 11111", 5'b11111, 32'hDEAD_BEEF, 32'h1234_5678, 0);

      // Competing start during mul EXEC is dropped.
      run_op("mul with busy start", 5'b01111, 32'd1000, 32'd3000, 2);
      count_done(6, pulses);
      check("busy start not queued", 64'(pulses), 64'd0);

      for (int n = 0; n < 30; n++) begin
         r = $urandom_range(0, 15);
         op = (r < 13) ? LEGAL[r] : 5'($urandom_range(0, 31));
         a  = $urandom;
         b  = $urandom;
         if (op == 5'b10000 && b == 32'd0) b = 32'd1;
         run_op("random", op, a, b, 0);
      end

      // Make sure results are non-zero before the abort check.
      run_op("sub before clear", 5'b00100, 32'd100, 32'd1, 0);

      // clear at k+2 of a mul aborts it.
      bus.start     = 1'b1;
      bus.op_code   = 5'b01111;
      bus.operand_a = 32'd9;
      bus.operand_b = 32'd11;
      @(posedge clock);
      @(negedge clock);
      bus.start = 1'b0;
      @(posedge clock);
      @(negedge clock);
      clear = 1'b1;
      @(posedge clock);
      @(negedge clock);
      clear = 1'b0;
      check_all_zero("clear mid-mul");
      count_done(8, pulses);
      check("no done after clear", 64'(pulses), 64'd0);
      run_op("add 1+1 after clear", 5'b00011, 32'd1, 32'd1, 0);

      // clear and start on the same edge: request dropped.
      bus.start     = 1'b1;
      bus.op_code   = 5'b00011;
      bus.operand_a = 32'd3;
      bus.operand_b = 32'd4;
      clear         = 1'b1;
      @(posedge clock);
      @(negedge clock);
      clear     = 1'b0;
      bus.start = 1'b0;
      check_all_zero("clear with start");
      count_done(5, pulses);
      check("no done after clear+start", 64'(pulses), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
